// File: rtl/aritmetica_pipe.sv
// Two-stage signed fixed-point multiply-add: Valores = sat(addend + round(M*E)).
// The addend is Constantes_G or the previous Valores, which gives multi-tap accumulation.
module aritmetica_pipe #(
   parameter int unsigned N    = 25,
   parameter int unsigned FRAC = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [N-1:0] Constantes_G,
   input  logic [N-1:0] Multip_G,
   input  logic [N-1:0] Entrada_G,
   input  logic         acc_mode,
   input  logic         acc_clear,
   input  logic         ovf_clr,
   output logic         out_valid,
   output logic [N-1:0] Valores,
   output logic         ovf,
   output logic         ovf_sticky
);

   localparam int unsigned PW = 2 * N;
   localparam int unsigned RW = PW - FRAC;
   localparam int unsigned SW = RW + 1;

   localparam logic signed [PW-1:0] HALF  = PW'(1) << (FRAC - 1);
   localparam logic signed [SW-1:0] MAX_S = SW'({1'b0, {(N-1){1'b1}}});
   localparam logic signed [SW-1:0] MIN_S = ~MAX_S;
   localparam logic        [N-1:0]  MAX_N = {1'b0, {(N-1){1'b1}}};
   localparam logic        [N-1:0]  MIN_N = {1'b1, {(N-1){1'b0}}};

   // Stage-1 registers
   logic                   s1_valid_q, s1_valid_d;
   logic signed [RW-1:0]   r_q, r_d;
   logic        [N-1:0]    c_q, c_d;
   logic                   use_acc_q, use_acc_d;

   // Stage-2 (output) registers
   logic                   out_valid_q, out_valid_d;
   logic        [N-1:0]    valores_q, valores_d;
   logic                   ovf_q, ovf_d;
   logic                   ovf_sticky_q, ovf_sticky_d;

   logic signed [PW-1:0]   prod_c;
   logic signed [PW-1:0]   rnd_c;
   logic signed [N-1:0]    addend_c;
   logic signed [SW-1:0]   sum_c;

   // Stage 1: full product, round half toward +inf, keep all integer bits
   always_comb begin
      prod_c     = PW'($signed(Multip_G)) * PW'($signed(Entrada_G));
      rnd_c      = prod_c + HALF;
      s1_valid_d = in_valid;
      r_d        = r_q;
      c_d        = c_q;
      use_acc_d  = use_acc_q;
      if (in_valid) begin
         r_d       = RW'(rnd_c >>> FRAC);
         c_d       = Constantes_G;
         use_acc_d = acc_mode & ~acc_clear;
      end
   end

   // Stage 2: add, saturate, flag; feedback comes from the output register itself
   always_comb begin
      addend_c     = use_acc_q ? $signed(valores_q) : $signed(c_q);
      sum_c        = SW'(r_q) + SW'(addend_c);
      out_valid_d  = s1_valid_q;
      valores_d    = valores_q;
      ovf_d        = 1'b0;
      ovf_sticky_d = ovf_clr ? 1'b0 : ovf_sticky_q;
      if (s1_valid_q) begin
         if (sum_c > MAX_S) begin
            valores_d = MAX_N;
            ovf_d     = 1'b1;
         end else if (sum_c < MIN_S) begin
            valores_d = MIN_N;
            ovf_d     = 1'b1;
         end else begin
            valores_d = sum_c[N-1:0];
         end
      end
      // A new saturation beats a coincident clear
      if (ovf_d) begin
         ovf_sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q   <= 1'b0;
         r_q          <= '0;
         c_q          <= '0;
         use_acc_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         valores_q    <= '0;
         ovf_q        <= 1'b0;
         ovf_sticky_q <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         r_q          <= r_d;
         c_q          <= c_d;
         use_acc_q    <= use_acc_d;
         out_valid_q  <= out_valid_d;
         valores_q    <= valores_d;
         ovf_q        <= ovf_d;
         ovf_sticky_q <= ovf_sticky_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign Valores    = valores_q;
   assign ovf        = ovf_q;
   assign ovf_sticky = ovf_sticky_q;

endmodule
